// File: rtl/screen_sched.sv
// Frame-synchronous screen/menu scheduler: turns clicks, the back button and game_over
// into one-shot requests, holds one pending, and commits it at the start of vblank.
module screen_sched #(
  parameter int X_MIN      = 362,
  parameter int X_MAX      = 674,
  parameter int START_Y0   = 46,
  parameter int START_Y1   = 146,
  parameter int DIFF_Y0    = 238,
  parameter int DIFF_Y1    = 338,
  parameter int COLOR_Y0   = 430,
  parameter int COLOR_Y1   = 530,
  parameter int CRED_Y0    = 622,
  parameter int CRED_Y1    = 722,
  parameter int NUM_COLORS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        button,
  input  logic        game_over,
  output logic [1:0]  screen_sel,
  output logic        difficulty,
  output logic [2:0]  color_sel,
  output logic        pending,
  output logic        frame_tick
);

  typedef enum logic [2:0] {
    K_GO_GAME,
    K_GO_CRED,
    K_GO_MENU,
    K_TOG_DIFF,
    K_NEXT_COLOR
  } kind_t;

  localparam logic [1:0]  SCR_MENU  = 2'b00;
  localparam logic [1:0]  SCR_GAME  = 2'b01;
  localparam logic [1:0]  SCR_CRED  = 2'b10;
  localparam logic [1:0]  SCR_BAD   = 2'b11;
  localparam logic [11:0] XMN       = 12'(X_MIN);
  localparam logic [11:0] XMX       = 12'(X_MAX);
  localparam logic [11:0] SY0       = 12'(START_Y0);
  localparam logic [11:0] SY1       = 12'(START_Y1);
  localparam logic [11:0] DY0       = 12'(DIFF_Y0);
  localparam logic [11:0] DY1       = 12'(DIFF_Y1);
  localparam logic [11:0] CY0       = 12'(COLOR_Y0);
  localparam logic [11:0] CY1       = 12'(COLOR_Y1);
  localparam logic [11:0] RY0       = 12'(CRED_Y0);
  localparam logic [11:0] RY1       = 12'(CRED_Y1);
  localparam logic [2:0]  COLOR_TOP = 3'(NUM_COLORS - 1);

  logic        mouse_left_d, vblnk_d;
  logic        vld_p0;
  kind_t       pend_kind;
  logic        click, boundary, in_col;
  logic        req_vld;
  kind_t       req_kind;

  logic        mouse_left_d_nx, vblnk_d_nx, vld_nx, difficulty_nx, frame_tick_nx;
  kind_t       pend_kind_nx;
  logic [1:0]  screen_sel_nx;
  logic [2:0]  color_sel_nx;

  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == COLOR_TOP) ? 3'd0 : c + 3'd1;
  endfunction

  assign click    = mouse_left & ~mouse_left_d;
  assign boundary = vblnk_in & ~vblnk_d;
  assign in_col   = (xpos >= XMN) && (xpos <= XMX);
  assign pending  = vld_p0;

  // Request decode: which one-shot request, if any, the current cycle raises
  always_comb begin
    req_vld  = 1'b0;
    req_kind = K_GO_MENU;
    case (screen_sel)
      SCR_MENU: begin
        if (click && in_col) begin
          if (ypos >= SY0 && ypos <= SY1) begin
            req_vld = 1'b1; req_kind = K_GO_GAME;
          end else if (ypos >= DY0 && ypos <= DY1) begin
            req_vld = 1'b1; req_kind = K_TOG_DIFF;
          end else if (ypos >= CY0 && ypos <= CY1) begin
            req_vld = 1'b1; req_kind = K_NEXT_COLOR;
          end else if (ypos >= RY0 && ypos <= RY1) begin
            req_vld = 1'b1; req_kind = K_GO_CRED;
          end
        end
      end
      SCR_GAME: req_vld = button | game_over;
      SCR_CRED: req_vld = button;
      default:  req_vld = 1'b0;
    endcase
  end

  // Commit / accept: a boundary with a pending request wins and drops any new request
  always_comb begin
    mouse_left_d_nx = mouse_left;
    vblnk_d_nx      = vblnk_in;
    vld_nx          = vld_p0;
    pend_kind_nx    = pend_kind;
    screen_sel_nx   = screen_sel;
    difficulty_nx   = difficulty;
    color_sel_nx    = color_sel;
    frame_tick_nx   = 1'b0;
    if (screen_sel == SCR_BAD) begin
      screen_sel_nx = SCR_MENU;
      vld_nx        = 1'b0;
    end else if (boundary && vld_p0) begin
      vld_nx        = 1'b0;
      frame_tick_nx = 1'b1;
      case (pend_kind)
        K_GO_GAME:    screen_sel_nx = SCR_GAME;
        K_GO_CRED:    screen_sel_nx = SCR_CRED;
        K_GO_MENU:    screen_sel_nx = SCR_MENU;
        K_TOG_DIFF:   difficulty_nx = ~difficulty;
        K_NEXT_COLOR: color_sel_nx  = next_color(color_sel);
        default:      screen_sel_nx = SCR_MENU;
      endcase
    end else if (!vld_p0 && req_vld) begin
      vld_nx       = 1'b1;
      pend_kind_nx = req_kind;
    end
  end

  // Registered state; edge detectors reset high so levels held through reset are not edges
  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_left_d <= 1'b1;
      vblnk_d      <= 1'b1;
      vld_p0       <= 1'b0;
      pend_kind    <= K_GO_MENU;
      screen_sel   <= SCR_MENU;
      difficulty   <= 1'b0;
      color_sel    <= 3'd0;
      frame_tick   <= 1'b0;
    end else begin
      mouse_left_d <= mouse_left_d_nx;
      vblnk_d      <= vblnk_d_nx;
      vld_p0       <= vld_nx;
      pend_kind    <= pend_kind_nx;
      screen_sel   <= screen_sel_nx;
      difficulty   <= difficulty_nx;
      color_sel    <= color_sel_nx;
      frame_tick   <= frame_tick_nx;
    end
  end

endmodule

// File: doc/screen_sched.md
# screen_sched

Frame-synchronous screen and menu-option scheduler for the PONG display pipeline. It turns raw mouse clicks, the board button and the game-over flag into one-shot requests and holds at most one request pending. It commits that request only at the start of vertical blanking, so screen changes and palette/difficulty changes never occur mid-frame. Its outputs drive the rgb/sync multiplexer and the colour/difficulty inputs of the menu, game and credits renderers.

## Interface
Parameters:
- X_MIN, 362, left edge of all menu buttons (inclusive)
- X_MAX, 674, right edge of all menu buttons (inclusive)
- START_Y0 / START_Y1, 46 / 146, START button rows (inclusive)
- DIFF_Y0 / DIFF_Y1, 238 / 338, DIFFICULTY button rows
- COLOR_Y0 / COLOR_Y1, 430 / 530, COLOUR button rows
- CRED_Y0 / CRED_Y1, 622 / 722, CREDITS button rows
- NUM_COLORS, 7, number of palettes; color_sel wraps at NUM_COLORS-1

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset: synchronous, active-high, clock clk
- vblnk_in  in  1  vertical blank from timing generator
- xpos  in  12  mouse x
- ypos  in  12  mouse y
- mouse_left  in  1  left button level
- button  in  1  board "back" button level
- game_over  in  1  level from game logic, request return to menu
- screen_sel  out  2  00 MENU, 01 GAME, 10 CREDITS
- difficulty  out  1  committed difficulty
- color_sel  out  3  committed palette index
- pending  out  1  a request is waiting for commit
- frame_tick  out  1  one-cycle pulse in the cycle after a commit

## Operation
- Click = mouse_left rising edge: mouse_left=1 and mouse_left_d=0. mouse_left_d resets to 1, so a button held through reset is not a click.
- Frame boundary = vblnk_in rising edge: vblnk_in=1 and vblnk_d=0. vblnk_d resets to 1.
- Single pending slot: pend_valid plus pend_kind, with kinds GO_GAME, GO_CRED, GO_MENU, TOG_DIFF and NEXT_COLOR.
- Accepting a request: only when pend_valid=0. Requests arriving while pend_valid=1 are dropped, not queued.
- In MENU, on a click with X_MIN<=xpos<=X_MAX, the row decodes as START→GO_GAME, DIFF→TOG_DIFF, COLOR→NEXT_COLOR, CRED→GO_CRED. Clicks outside any button are ignored. Coordinates are sampled in the click cycle.
- In GAME or CREDITS, button=1 → GO_MENU. In GAME only, game_over=1 → GO_MENU. Button has priority; both are the same kind, so priority affects no outcome. Clicks are ignored in GAME and CREDITS.
- Commit at a frame boundary with pend_valid=1:
  - GO_* sets screen_sel.
  - TOG_DIFF inverts difficulty.
  - NEXT_COLOR sets color_sel to color_sel+1, or 0 if color_sel=NUM_COLORS-1.
  - Commit clears pend_valid and pulses frame_tick.
- A frame boundary with pend_valid=0 does nothing, and frame_tick stays 0.
- screen_sel=11 is illegal. At the next clock it is forced to MENU and pend_valid is cleared.
- A held button after the return to MENU has no effect, because button is ignored in MENU. A mouse held across the return to MENU produces no click until it is released and pressed again.

## Timing
- Reset values: screen_sel=00, difficulty=0, color_sel=0, pending=0, frame_tick=0.
- Reset mid-operation discards any pending request.
- Request latency: a click or button in cycle t sets pending=1 at t+1.
- Commit latency: a frame boundary in cycle b updates screen_sel, difficulty and color_sel at b+1. frame_tick=1 for cycle b+1 only.
- Click and boundary in the same cycle with pend_valid=0: the boundary commits nothing. The click becomes pending and commits at the next boundary.
- Click and boundary in the same cycle with pend_valid=1: the old request commits and the new click is dropped.
- A request is never committed in the cycle it is accepted. The minimum request-to-output delay is 2 cycles.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Test plan
- Reset with mouse_left=1 held, then vblnk pulses → screen_sel stays 00 and pending stays 0.
- MENU, click at (500,100), vblnk rises 50 cycles later → pending=1 one cycle after the click. screen_sel=01 and frame_tick=1 one cycle after the vblnk edge; pending=0.
- MENU, 8 separate clicks at (500,480), each followed by a vblnk edge → color_sel goes 1,2,3,4,5,6,0,1 and difficulty stays 0.
- MENU, clicks at (500,300) then (500,680) within one frame → difficulty=1 after the first boundary, and screen_sel stays 00 because the second click was dropped.
- GAME with button=1 held for 3 frames → screen_sel=00 after the first boundary. A subsequent held mouse_left does not start the game until it is released and re-pressed.
- Click edge coincident with a vblnk edge, pending=0 → no change at that boundary. The change appears at the following vblnk edge +1 cycle.
